// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder feeding a 2-entry valid/ready output buffer,
// with a saturating count of accepted illegal opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;
    localparam logic [2:0] F_ILL  = 3'd7;
    localparam bit IS64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic [2:0]       in_fmt;
    logic [XLEN-1:0]  in_imm;
    ent_t             in_ent, h_q, h_d, t_q, t_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop, load_new;

    always_comb begin
        in_fmt = F_ILL;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: in_fmt = F_I;
            7'b0011011: in_fmt = IS64 ? F_I : F_ILL;
            7'b0100011: in_fmt = F_S;
            7'b1100011: in_fmt = F_B;
            7'b0110111, 7'b0010111: in_fmt = F_U;
            7'b1101111: in_fmt = F_J;
            7'b0110011: in_fmt = F_NONE;
            7'b0111011: in_fmt = IS64 ? F_NONE : F_ILL;
            default: in_fmt = F_ILL;
        endcase
    end

    // Size casts of signed slices perform the sign extension to XLEN.
    always_comb begin
        in_imm = '0;
        case (in_fmt)
            F_I: in_imm = XLEN'($signed(in_instr[31:20]));
            F_S: in_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            F_B: in_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
            F_U: in_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            F_J: in_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
            default: in_imm = '0;
        endcase
    end

    assign in_ent    = '{imm: in_imm, fmt: in_fmt, tag: in_tag};
    assign in_ready  = reset && !flush && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // A push lands in the head slot when the head is empty or being vacated this cycle.
    always_comb begin
        load_new = push && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
        occ_d    = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
        h_d      = load_new ? in_ent : (pop && (occ_q == 2'd2)) ? t_q : h_q;
        t_d      = (push && !load_new) ? in_ent : t_q;
        cnt_d    = clr_cnt ? '0 :
                   (push && (in_fmt == F_ILL) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= 2'd0;
            h_q   <= '0;
            t_q   <= '0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            h_q   <= h_d;
            t_q   <= t_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_imm     = h_q.imm;
    assign out_fmt     = h_q.fmt;
    assign out_tag     = h_q.tag;
    assign out_illegal = (h_q.fmt == F_ILL);
    assign illegal_cnt = cnt_q;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It decodes every RV32I/RV64I immediate format (I, S, B, U, J) and sign-extends the result to XLEN. It classifies each instruction's format and flags unsupported opcodes. It adds a 2-entry valid/ready output buffer with flush, so that decode can be decoupled from the ID/EX register.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 32: width of the sideband tag (PC or ROB id) carried with each instruction.
- CNT_W, 8: width of the saturating illegal-opcode counter.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; empties the buffer.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; equals reset && !flush && (occupancy != 2). No path from out_ready.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format: 0 NONE (R-type), 1 I, 2 S, 3 B, 4 U, 5 J, 7 ILLEGAL.
- out_illegal  out  1  opcode not supported.
- out_tag  out  TAG_W  tag of the head entry.
- clr_cnt  in  1  synchronous clear of illegal_cnt.
- illegal_cnt  out  CNT_W  count of accepted illegal instructions; saturates.

## Operation
- The block decodes in_instr[6:0] combinationally at the input. The decoded result is written into a 2-entry FIFO on an input handshake (in_valid && in_ready).
- Opcode map:
  - 0000011, 0010011, 1100111, 1110011 → I.
  - 0011011 → I only when XLEN=64; otherwise ILLEGAL.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → NONE; also 0111011 when XLEN=64.
  - All other opcodes → ILLEGAL.
- Immediate construction, with s = instr[31] replicated to fill XLEN:
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - U: {s, instr[31:12], 12'b0}.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - NONE and ILLEGAL: 0.
- Shift-immediate instructions are not special-cased; the raw I immediate is produced.
- out_illegal = (out_fmt == 7).
- FIFO behaviour:
  - Occupancy is 0, 1 or 2.
  - Push on input handshake; pop on out_valid && out_ready.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1 and order is preserved.
  - At occupancy 2, no push is possible (in_ready = 0); a pop at occupancy 2 raises in_ready on the following cycle.
  - Output fields hold stable while out_valid && !out_ready.
- Flush:
  - Occupancy goes to 0 at the next edge and out_valid drops.
  - in_ready is 0 during the flush cycle, so no push occurs.
  - A pop in the same cycle as a flush is discarded.
  - Flush does not affect illegal_cnt.
- illegal_cnt:
  - Increments by 1 on each input handshake whose format is ILLEGAL.
  - Saturates at 2^CNT_W − 1.
  - clr_cnt has priority: a clear coinciding with an illegal accept yields 0.
- Reset (asynchronous, at any time, including mid-transfer):
  - Occupancy 0 and out_valid 0.
  - out_imm, out_fmt, out_illegal and out_tag all 0.
  - illegal_cnt 0.
  - in_ready 0 while reset is low.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k is presented with out_valid = 1 after edge k.
- Throughput is 1 instruction per cycle when out_ready is held high.
- Outputs are driven from registers only. The only combinational paths are from flush and reset to in_ready.
- in_ready first asserts in the first cycle after reset is deasserted.

## Test plan
- XLEN=32; addi 0xFFF00093 at edge 1 → after edge 1: out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_tag matches in_tag.
- beq 0xFE000EE3, then jal 0x001000EF, back-to-back with out_ready=1 → out_imm 0xFFFFFFFC (fmt 3), then 0x00000800 (fmt 5), on consecutive cycles.
- lui 0x123452B7 → out_imm 0x12345000, fmt 4. With XLEN=64, lui 0x800002B7 → 0xFFFFFFFF80000000, and 0x0000009B (addiw) → fmt 1; the same addiw with XLEN=32 → fmt 7.
- out_ready=0, push three instructions A, B, C → in_ready=0 after A and B are stored, C is held. Raise out_ready → outputs A, B, C in order, with no loss or duplication.
- CNT_W=2; push 0x0000007F four times → illegal_cnt goes 1, 2, 3, 3 and out_illegal=1 for each. Then assert clr_cnt together with a fifth illegal push → illegal_cnt=0.
- Buffer full with out_ready=0: assert flush → out_valid=0 next cycle. Separately, assert reset low mid-stream → every output is 0 immediately (asynchronously), and traffic resumes correctly after release.
